gate_sequencer: RTL and testbench
=================================

# gate_sequencer

Sequences the parking lot's single shared barrier door between the entry and exit sensors. It latches sensor requests and arbitrates fairly when both are pending. It allocates or frees one of four parking slots, holds the door open for a tick-counted interval, and signals a full-lot rejection. It sits between the sensor inputs and the frequency divider tick on one side, and the slot LEDs, door light, full light and capacity / best-place display path on the other.

## Interface
- OPEN_TICKS, 3: number of `tick` pulses the door stays open per grant (≥1).
- FULL_TICKS, 2: number of `tick` pulses `full_light` stays lit after a rejected entry (≥1).
- clk  in  1  system clock (40 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle enable from the frequency divider (1 Hz), synchronous to `clk`.
- entry_sensor  in  1  car at entry; rising edge = one entry request.
- exit_sensor  in  1  car at exit; rising edge = one exit request.
- exit_slot  in  2  slot index being vacated, sampled when an exit is granted.
- parking_slots  out  4  occupancy, bit i = slot i occupied.
- door_open_light  out  1  door open.
- full_light  out  1  entry rejected, lot full.
- capacity  out  3  free slots, 0..4.
- best_place  out  2  slot assigned to the most recent granted entry.
- entry_grant  out  1  one-cycle pulse on entry service.
- exit_grant  out  1  one-cycle pulse on exit service.
- exit_error  out  1  one-cycle pulse: exit requested for an empty slot.
- busy  out  1  high in any state other than IDLE.

## Operation
- Edge detect: registered `entry_prev`/`exit_prev` (reset 0). A rising edge sets `pend_entry`/`pend_exit`. A sensor held high through reset release counts as an edge. Multiple edges while a request is pending coalesce into one.
- If a set and a clear of the same pending flag happen on the same edge, the set wins.
- States:
  - IDLE: waits for a pending request.
  - OPEN: door open, counting ticks.
  - REJECT: full light lit, counting ticks.
- IDLE arbitration:
  - One flag pending → serve it.
  - Both pending → serve the direction opposite to `last_served`. Reset value of `last_served` = exit, so entry wins first.
  - The served pending flag clears and `last_served` updates.
- Entry served, lot not full:
  - Set the lowest-index free slot bit; `best_place` ← that index.
  - Pulse `entry_grant`; go to OPEN.
- Entry served, lot full (`parking_slots`=4'b1111):
  - No slot change; go to REJECT. The entry counts as served for fairness.
- Exit served:
  - `exit_slot` occupied → clear that bit, pulse `exit_grant`, go to OPEN.
  - `exit_slot` empty → pulse `exit_error`, stay in IDLE; the request is dropped.
- OPEN: `door_open_light`=1. Counter reset to 0 on entry to the state and incremented on each `tick`. When the count reaches OPEN_TICKS, go to IDLE on that edge.
- REJECT: `full_light`=1. Same counting with FULL_TICKS, then IDLE.
- Requests arriving during OPEN/REJECT are latched and served from IDLE afterward.
- `capacity` is registered and always equals 4 − popcount(`parking_slots`). It updates on the same edge as the slots.
- Counter width = clog2(max(OPEN_TICKS, FULL_TICKS)+1). The counter never wraps.

## Timing
- Reset values: `parking_slots`=0, `door_open_light`=0, `full_light`=0, `capacity`=4, `best_place`=0, all grant/error pulses 0, `busy`=0, state IDLE, pending flags 0.
- Reset asserted mid-OPEN/REJECT closes the door and clears the light immediately; all state is lost.
- Latency: sensor rises before edge k → pending set at edge k → grant at edge k+1. Slots, `capacity`, `best_place`, the grant pulse and `door_open_light` are all valid after edge k+1.
- Door/light duration: OPEN_TICKS (or FULL_TICKS) `tick` pulses after entering the state. A `tick` in the same cycle as the grant edge is not counted. The output drops on the edge that samples the final tick.
- The earliest next grant is the edge after return to IDLE (one idle cycle minimum).
- All outputs are registered; no combinational input→output paths.

## Test plan
- Reset, then four entry edges spaced past each door interval → slots 0001, 0011, 0111, 1111; `best_place` 0,1,2,3; `capacity` 3,2,1,0; each `door_open_light` lasts exactly 3 ticks.
- Lot full, entry edge → `full_light` high for 2 ticks, no `entry_grant`, slots stay 1111, `capacity` stays 0.
- Slots 1111, `exit_slot`=2, exit edge → slots 1011, `capacity`=1, `exit_grant` pulse. Next entry → `best_place`=2.
- Slots 0101, entry and exit edges on the same cycle with `exit_slot`=0 → entry served first (slot 1, slots 0111). After that door cycle, exit served → slots 0110. Repeat the simultaneous pair → exit now served first.
- Slots 0000, exit edge with `exit_slot`=3 → single `exit_error` pulse, no door, `busy` stays 0.
- Assert `rst` during OPEN with one slot occupied → `door_open_light`=0 and `parking_slots`=0 immediately, `capacity`=4. A pending entry latched before reset is discarded.

Source files
------------

// File: rtl/gate_sequencer_if.sv
// rtl/gate_sequencer_if.sv - sensor/tick inputs and door/slot status outputs of the gate sequencer
interface gate_sequencer_if;
  logic       tick;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] exit_slot;
  logic [3:0] parking_slots;
  logic       door_open_light;
  logic       full_light;
  logic [2:0] capacity;
  logic [1:0] best_place;
  logic       entry_grant;
  logic       exit_grant;
  logic       exit_error;
  logic       busy;

  modport master (
    output tick, entry_sensor, exit_sensor, exit_slot,
    input  parking_slots, door_open_light, full_light, capacity, best_place,
           entry_grant, exit_grant, exit_error, busy
  );

  modport slave (
    input  tick, entry_sensor, exit_sensor, exit_slot,
    output parking_slots, door_open_light, full_light, capacity, best_place,
           entry_grant, exit_grant, exit_error, busy
  );
endinterface

// File: rtl/gate_sequencer.sv
// rtl/gate_sequencer.sv - shared barrier door sequencer: latches entry/exit requests,
// arbitrates fairly, allocates/frees one of four slots and times the door/full lights.
module gate_sequencer #(
  parameter int OPEN_TICKS = 3,
  parameter int FULL_TICKS = 2
) (
  input logic              clk,
  input logic              rst,
  gate_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_REJECT} state_t;

  localparam int MAX_TICKS = (OPEN_TICKS > FULL_TICKS) ? OPEN_TICKS : FULL_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_TICKS);
  localparam logic [CW-1:0] FULL_LAST = CW'(FULL_TICKS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          entry_prev_q, exit_prev_q;
  logic          pend_entry_q, pend_entry_d, pend_exit_q, pend_exit_d;
  logic          last_exit_q, last_exit_d;
  logic [3:0]    slots_q, slots_d;
  logic [2:0]    cap_q, cap_d;
  logic [1:0]    best_q, best_d;
  logic          entry_grant_q, entry_grant_d;
  logic          exit_grant_q, exit_grant_d;
  logic          exit_error_q, exit_error_d;
  logic          door_q, full_q, busy_q;
  logic          serve_entry, serve_exit;
  logic [1:0]    free_idx;
  logic          entry_rise, exit_rise;

  function automatic logic [2:0] ones4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign entry_rise = bus.entry_sensor & ~entry_prev_q;
  assign exit_rise  = bus.exit_sensor & ~exit_prev_q;
  assign cnt_inc    = cnt_q + CW'(1);

  // Lowest-index free slot; only meaningful when the lot is not full.
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!slots_q[i]) free_idx = 2'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slots_d       = slots_q;
    best_d        = best_q;
    last_exit_d   = last_exit_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    exit_error_d  = 1'b0;
    serve_entry   = 1'b0;
    serve_exit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // With both pending, the direction not served last time goes first.
        if (pend_entry_q && (!pend_exit_q || last_exit_q)) serve_entry = 1'b1;
        else if (pend_exit_q)                              serve_exit  = 1'b1;

        if (serve_entry) begin
          last_exit_d = 1'b0;
          cnt_d       = '0;
          if (slots_q != 4'b1111) begin
            slots_d       = slots_q | (4'b0001 << free_idx);
            best_d        = free_idx;
            entry_grant_d = 1'b1;
            state_d       = S_OPEN;
          end else begin
            state_d = S_REJECT;
          end
        end

        if (serve_exit) begin
          last_exit_d = 1'b1;
          cnt_d       = '0;
          if (slots_q[bus.exit_slot]) begin
            slots_d      = slots_q & ~(4'b0001 << bus.exit_slot);
            exit_grant_d = 1'b1;
            state_d      = S_OPEN;
          end else begin
            exit_error_d = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (bus.tick) begin
          if (cnt_inc == OPEN_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_REJECT: begin
        if (bus.tick) begin
          if (cnt_inc == FULL_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge on the same cycle as service re-arms the request.
    pend_entry_d = (pend_entry_q & ~serve_entry) | entry_rise;
    pend_exit_d  = (pend_exit_q & ~serve_exit) | exit_rise;
    cap_d        = 3'd4 - ones4(slots_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      entry_prev_q  <= 1'b0;
      exit_prev_q   <= 1'b0;
      pend_entry_q  <= 1'b0;
      pend_exit_q   <= 1'b0;
      last_exit_q   <= 1'b1;
      slots_q       <= 4'b0000;
      cap_q         <= 3'd4;
      best_q        <= 2'd0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      exit_error_q  <= 1'b0;
      door_q        <= 1'b0;
      full_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      entry_prev_q  <= bus.entry_sensor;
      exit_prev_q   <= bus.exit_sensor;
      pend_entry_q  <= pend_entry_d;
      pend_exit_q   <= pend_exit_d;
      last_exit_q   <= last_exit_d;
      slots_q       <= slots_d;
      cap_q         <= cap_d;
      best_q        <= best_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      exit_error_q  <= exit_error_d;
      door_q        <= (state_d == S_OPEN);
      full_q        <= (state_d == S_REJECT);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign bus.parking_slots   = slots_q;
  assign bus.door_open_light = door_q;
  assign bus.full_light      = full_q;
  assign bus.capacity        = cap_q;
  assign bus.best_place      = best_q;
  assign bus.entry_grant     = entry_grant_q;
  assign bus.exit_grant      = exit_grant_q;
  assign bus.exit_error      = exit_error_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_gate_sequencer.sv
// tb/tb_gate_sequencer.sv - bench for gate_sequencer: vector table, corner sequences, random vs model
module tb_gate_sequencer;
  localparam int OPEN_T = 3;
  localparam int FULL_T = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  gate_sequencer_if bus_if ();

  gate_sequencer #(.OPEN_TICKS(OPEN_T), .FULL_TICKS(FULL_T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ex;
    logic [1:0]  slot;
    logic        tk;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Expected-output packing: slots, door, full, capacity, best, entry_grant, exit_grant, exit_error, busy
  function automatic logic [14:0] pk(int s, int d, int f, int c, int b, int eg, int xg, int er, int bz);
    return {4'(s), 1'(d), 1'(f), 3'(c), 2'(b), 1'(eg), 1'(xg), 1'(er), 1'(bz)};
  endfunction

  function automatic logic [14:0] act();
    return {bus_if.parking_slots, bus_if.door_open_light, bus_if.full_light, bus_if.capacity,
            bus_if.best_place, bus_if.entry_grant, bus_if.exit_grant, bus_if.exit_error, bus_if.busy};
  endfunction

  task automatic chk(string nm, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
  endtask

  // Reference model: occupancy array, pending requests, countdown of ticks left.
  bit m_occ[4];
  bit m_pe, m_px, m_pv_e, m_pv_x, m_last_exit, m_eg, m_xg, m_err;
  int m_mode;  // 0 idle, 1 door open, 2 full light
  int m_left, m_best;

  task automatic model_reset();
    foreach (m_occ[i]) m_occ[i] = 0;
    m_pe = 0; m_px = 0; m_pv_e = 0; m_pv_x = 0; m_last_exit = 1;
    m_eg = 0; m_xg = 0; m_err = 0; m_mode = 0; m_left = 0; m_best = 0;
  endtask

  task automatic model_step(bit en, bit ex, int slot, bit tk);
    bit re = en && !m_pv_e;
    bit rx = ex && !m_pv_x;
    bit se = 0, sx = 0;
    int fr = -1;
    m_eg = 0; m_xg = 0; m_err = 0;
    if (m_mode == 0) begin
      if (m_pe && m_px) begin
        if (m_last_exit) se = 1; else sx = 1;
      end else if (m_pe) se = 1;
      else if (m_px) sx = 1;
      if (se) begin
        m_last_exit = 0;
        for (int i = 3; i >= 0; i--) if (!m_occ[i]) fr = i;
        if (fr >= 0) begin
          m_occ[fr] = 1; m_best = fr; m_eg = 1; m_mode = 1; m_left = OPEN_T;
        end else begin
          m_mode = 2; m_left = FULL_T;
        end
      end
      if (sx) begin
        m_last_exit = 1;
        if (m_occ[slot]) begin
          m_occ[slot] = 0; m_xg = 1; m_mode = 1; m_left = OPEN_T;
        end else m_err = 1;
      end
    end else if (tk) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    m_pe = (m_pe && !se) || re;
    m_px = (m_px && !sx) || rx;
    m_pv_e = en; m_pv_x = ex;
  endtask

  function automatic logic [14:0] model_out();
    int s = 0, n = 0;
    for (int i = 0; i < 4; i++) if (m_occ[i]) begin s += (1 << i); n++; end
    return pk(s, m_mode == 1, m_mode == 2, 4 - n, m_best, m_eg, m_xg, m_err, m_mode != 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.tick = 0; bus_if.entry_sensor = 0; bus_if.exit_sensor = 0; bus_if.exit_slot = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic entry_pulse();
    bus_if.entry_sensor = 1; step();
    bus_if.entry_sensor = 0; step();
  endtask

  task automatic exit_pulse(int s);
    bus_if.exit_slot = 2'(s);
    bus_if.exit_sensor = 1; step();
    bus_if.exit_sensor = 0; step();
  endtask

  // Ticks every cycle; returns how many ticks were applied until busy dropped.
  task automatic tick_until_idle(output int n);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      bus_if.tick = 1; step(); n++;
      if (!bus_if.busy) break;
    end
    bus_if.tick = 0;
  endtask

  initial begin
    int n;
    int bad;

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, pk(0, 0, 0, 4, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, pk(1, 1, 0, 3, 0, 1, 0, 0, 1)};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, pk(1, 1, 0, 3, 0, 0, 0, 0, 1)};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, pk(1, 1, 0, 3, 0, 0, 0, 0, 1)};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, pk(1, 0, 0, 3, 0, 0, 0, 0, 0)};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, pk(1, 0, 0, 3, 0, 0, 0, 0, 0)};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, pk(3, 1, 0, 2, 1, 1, 0, 0, 1)};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, pk(3, 1, 0, 2, 1, 0, 0, 0, 1)};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, pk(3, 1, 0, 2, 1, 0, 0, 0, 1)};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, pk(3, 1, 0, 2, 1, 0, 0, 0, 1)};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b1, pk(3, 0, 0, 2, 1, 0, 0, 0, 0)};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, pk(2, 1, 0, 3, 1, 0, 1, 0, 1)};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, pk(2, 1, 0, 3, 1, 0, 0, 0, 1)};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b1, pk(2, 1, 0, 3, 1, 0, 0, 0, 1)};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b1, pk(2, 0, 0, 3, 1, 0, 0, 0, 0)};
    vecs[15] = '{1'b0, 1'b1, 2'd3, 1'b0, pk(2, 0, 0, 3, 1, 0, 0, 0, 0)};
    vecs[16] = '{1'b0, 1'b0, 2'd3, 1'b0, pk(2, 0, 0, 3, 1, 0, 0, 1, 0)};
    vecs[17] = '{1'b0, 1'b0, 2'd3, 1'b0, pk(2, 0, 0, 3, 1, 0, 0, 0, 0)};

    do_reset();
    chk("reset_state", act(), pk(0, 0, 0, 4, 0, 0, 0, 0, 0));

    for (int v = 0; v < 18; v++) begin
      bus_if.entry_sensor = vecs[v].en;
      bus_if.exit_sensor  = vecs[v].ex;
      bus_if.exit_slot    = vecs[v].slot;
      bus_if.tick         = vecs[v].tk;
      step();
      chk($sformatf("vec%0d", v), act(), vecs[v].exp);
    end

    // Fill the lot, reject when full, free slot 2 and refill it.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      entry_pulse();
      chk("fill_slots", bus_if.parking_slots, (1 << (i + 1)) - 1);
      chk("fill_best", bus_if.best_place, i);
      chk("fill_cap", bus_if.capacity, 3 - i);
      chk("fill_grant", bus_if.entry_grant, 1);
      tick_until_idle(n);
      chk("door_ticks", n, OPEN_T);
    end
    entry_pulse();
    chk("full_light", bus_if.full_light, 1);
    chk("full_no_grant", bus_if.entry_grant, 0);
    chk("full_slots", bus_if.parking_slots, 4'b1111);
    chk("full_cap", bus_if.capacity, 0);
    tick_until_idle(n);
    chk("full_ticks", n, FULL_T);
    exit_pulse(2);
    chk("exit2_slots", bus_if.parking_slots, 4'b1011);
    chk("exit2_cap", bus_if.capacity, 1);
    chk("exit2_grant", bus_if.exit_grant, 1);
    tick_until_idle(n);
    entry_pulse();
    chk("refill_best", bus_if.best_place, 2);
    tick_until_idle(n);

    // Fair arbitration of simultaneous requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin entry_pulse(); tick_until_idle(n); end
    exit_pulse(1); tick_until_idle(n);
    chk("fair_setup", bus_if.parking_slots, 4'b0101);
    bus_if.exit_slot = 0; bus_if.entry_sensor = 1; bus_if.exit_sensor = 1; step();
    bus_if.entry_sensor = 0; bus_if.exit_sensor = 0; step();
    chk("pair1_entry_first", act(), pk(7, 1, 0, 1, 1, 1, 0, 0, 1));
    tick_until_idle(n); step();
    chk("pair1_exit_second", act(), pk(6, 1, 0, 2, 1, 0, 1, 0, 1));
    tick_until_idle(n);
    entry_pulse(); tick_until_idle(n);
    chk("single_entry", bus_if.parking_slots, 4'b0111);
    bus_if.exit_slot = 0; bus_if.entry_sensor = 1; bus_if.exit_sensor = 1; step();
    bus_if.entry_sensor = 0; bus_if.exit_sensor = 0; step();
    chk("pair2_exit_first", act(), pk(6, 1, 0, 2, 0, 0, 1, 0, 1));
    tick_until_idle(n); step();
    chk("pair2_entry_second", act(), pk(7, 1, 0, 1, 0, 1, 0, 0, 1));
    tick_until_idle(n);

    // Exit for an empty slot.
    do_reset();
    exit_pulse(3);
    chk("empty_exit_err", act(), pk(0, 0, 0, 4, 0, 0, 0, 1, 0));
    step();
    chk("empty_exit_after", act(), pk(0, 0, 0, 4, 0, 0, 0, 0, 0));

    // Reset during OPEN with an entry request already latched.
    do_reset();
    entry_pulse();
    chk("pre_rst_door", bus_if.door_open_light, 1);
    bus_if.entry_sensor = 1; step();
    bus_if.entry_sensor = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", act(), pk(0, 0, 0, 4, 0, 0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      bus_if.tick = 1; step();
      if (bus_if.entry_grant || bus_if.parking_slots != 0 || bus_if.busy) bad++;
    end
    bus_if.tick = 0;
    chk("rst_drops_pending", bad, 0);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) bus_if.entry_sensor = ~bus_if.entry_sensor;
      if ($urandom_range(3) == 0) bus_if.exit_sensor  = ~bus_if.exit_sensor;
      bus_if.exit_slot = 2'($urandom_range(3));
      bus_if.tick      = ($urandom_range(2) == 0);
      @(posedge clk);
      model_step(bus_if.entry_sensor, bus_if.exit_sensor, int'(bus_if.exit_slot), bus_if.tick);
      #1;
      chk("random", act(), model_out());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
